// File: rtl/pwm_peripheral.sv
// -----------------------------------------------------------------------------
// pwm_peripheral
//   Drives 16 output pins from the SPI-written configuration registers. Each
//   pin is held low, held high, or follows one shared 8-bit PWM waveform. The
//   duty value is double-buffered into a shadow register that only reloads at
//   the PWM period wrap, so a duty write never produces a runt pulse.
//
// Parameters
//   CLK_DIV          clk cycles per PWM counter step (1..256)
//
// Ports
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   en_reg_out_7_0   output enable, pins 7..0
//   en_reg_out_15_8  output enable, pins 15..8
//   en_reg_pwm_7_0   PWM select, pins 7..0
//   en_reg_pwm_15_8  PWM select, pins 15..8
//   pwm_duty_cycle   requested duty (0x00..0xFF)
//   out              registered pin drive, bit i is pin i
//   period_start     one-clk pulse in the first cycle of each new PWM period
// -----------------------------------------------------------------------------
module pwm_peripheral #(
    parameter int CLK_DIV = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    // Terminal prescaler count; 8 bits cover the whole 1..256 range.
    localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

    logic [7:0]  r_prescale_cnt;
    logic [7:0]  r_pwm_cnt;
    logic [7:0]  r_duty_shadow;
    logic        r_primed;
    logic [15:0] r_out;
    logic        r_period_start;

    logic        w_tick;
    logic        w_wrap;
    logic        w_pwm_level;
    logic [15:0] w_en_out;
    logic [15:0] w_en_pwm;
    logic [15:0] w_out_next;

    // 0xFF means fully on; a plain compare would leave count 255 low.
    function automatic logic pwm_compare(input logic [7:0] cnt,
                                         input logic [7:0] duty);
        if (duty == 8'hFF) begin
            return 1'b1;
        end
        return (cnt < duty);
    endfunction

    // Disabled pins are 0 regardless of PWM select; enabled pins are either
    // the PWM level or a constant 1.
    function automatic logic [15:0] pin_mux(input logic [15:0] en_out,
                                            input logic [15:0] en_pwm,
                                            input logic        level);
        return en_out & (~en_pwm | {16{level}});
    endfunction

    assign w_tick      = (r_prescale_cnt == DIV_MAX);
    assign w_wrap      = w_tick && (r_pwm_cnt == 8'hFF);
    assign w_en_out    = {en_reg_out_15_8, en_reg_out_7_0};
    assign w_en_pwm    = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign w_pwm_level = pwm_compare(r_pwm_cnt, r_duty_shadow);
    assign w_out_next  = pin_mux(w_en_out, w_en_pwm, w_pwm_level);

    // Prescaler and PWM period counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prescale_cnt <= 8'd0;
            r_pwm_cnt      <= 8'd0;
        end else begin
            r_prescale_cnt <= w_tick ? 8'd0 : r_prescale_cnt + 8'd1;
            if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + 8'd1;
            end
        end
    end

    // Duty shadow: primed once after reset so the first period is not stuck at
    // the reset value of 0, then reloaded only on the wrap edge. A duty write
    // landing on the wrap edge itself is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_shadow <= 8'd0;
            r_primed      <= 1'b0;
        end else begin
            r_primed <= 1'b1;
            if (!r_primed || w_wrap) begin
                r_duty_shadow <= pwm_duty_cycle;
            end
        end
    end

    // Output stage: pins and period pulse are registered, so no input reaches
    // the outputs combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out          <= 16'h0000;
            r_period_start <= 1'b0;
        end else begin
            r_out          <= w_out_next;
            r_period_start <= w_wrap;
        end
    end

    assign out          = r_out;
    assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm_peripheral.sv
// -----------------------------------------------------------------------------
// tb_pwm_peripheral
//   Directed bench for pwm_peripheral. One instance uses CLK_DIV=13 (period
//   3328 clks), a second uses CLK_DIV=1 (period 256 clks) with pin 0 enabled
//   for PWM at duty 0x01. Index 0 of a measurement window is the cycle in
//   which period_start is seen high; out at index k reflects the counter at
//   index k-1.
// -----------------------------------------------------------------------------
module tb_pwm_peripheral;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] en_out = 16'h0000;
    logic [15:0] en_pwm = 16'h0000;
    logic [7:0]  duty = 8'h00;
    logic [15:0] out1;
    logic        ps1;
    logic [15:0] out2;
    logic        ps2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_peripheral #(.CLK_DIV(13)) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_out[7:0]),
        .en_reg_out_15_8 (en_out[15:8]),
        .en_reg_pwm_7_0  (en_pwm[7:0]),
        .en_reg_pwm_15_8 (en_pwm[15:8]),
        .pwm_duty_cycle  (duty),
        .out             (out1),
        .period_start    (ps1)
    );

    pwm_peripheral #(.CLK_DIV(1)) u_dut_div1 (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (8'h01),
        .en_reg_out_15_8 (8'h00),
        .en_reg_pwm_7_0  (8'h01),
        .en_reg_pwm_15_8 (8'h00),
        .pwm_duty_cycle  (8'h01),
        .out             (out2),
        .period_start    (ps2)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ps1(input string tag);
        int found;
        found = 0;
        for (int n = 0; n < 4000; n++) begin
            step();
            if (ps1) begin
                found = 1;
                break;
            end
        end
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        int n;
        int hi;
        int hi_b;
        int ps_cnt;
        int bad;
        logic v_at1;
        logic v_at1664;
        logic v_at1665;
        logic ps_last;

        // ---- 1: reset state, static enables, async reset ----
        en_out = 16'hFFFF;
        en_pwm = 16'h0000;
        duty   = 8'h00;
        repeat (3) step();
        check("rst_out", 32'(out1), 32'h0);
        check("rst_ps", 32'(ps1), 32'h0);
        check("rst_out_div1", 32'(out2), 32'h0);
        rst_n = 1'b1;
        step();
        check("static_out_1clk", 32'(out1), 32'hFFFF);
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        check("async_rst_out", 32'(out1), 32'h0);
        #3;
        rst_n = 1'b1;
        step();
        check("static_out_after_rerelease", 32'(out1), 32'hFFFF);
        check("div1_no_ps_at_start", 32'(ps2), 32'h0);
        n = 1;
        while (!ps2 && n < 300) begin
            step();
            n++;
        end
        check("div1_first_ps_clks", 32'(n), 32'd256);

        // ---- 2: duty 0x80 on pin 0 ----
        en_out = 16'h0001;
        en_pwm = 16'h0001;
        duty   = 8'h80;
        wait_ps1("t2_wait_ps");
        hi = 0; ps_cnt = 0; bad = 0;
        v_at1 = 1'b0; v_at1664 = 1'b0; v_at1665 = 1'b1; ps_last = 1'b0;
        for (int i = 1; i <= 3328; i++) begin
            step();
            hi += int'(out1[0]);
            bad += int'(out1[15:1] != 15'h0);
            if (i == 1) v_at1 = out1[0];
            if (i == 1664) v_at1664 = out1[0];
            if (i == 1665) v_at1665 = out1[0];
            if (i < 3328) ps_cnt += int'(ps1);
            else ps_last = ps1;
        end
        check("t2_high_clks", 32'(hi), 32'd1664);
        check("t2_low_clks", 32'(3328 - hi), 32'd1664);
        check("t2_rise_idx1", 32'(v_at1), 32'h1);
        check("t2_last_high_idx1664", 32'(v_at1664), 32'h1);
        check("t2_fall_idx1665", 32'(v_at1665), 32'h0);
        check("t2_no_early_ps", 32'(ps_cnt), 32'd0);
        check("t2_ps_at_3328", 32'(ps_last), 32'h1);
        check("t2_other_pins", 32'(bad), 32'd0);

        // ---- 3: duty extremes on pin 15 ----
        en_out = 16'h8000;
        en_pwm = 16'h8000;
        duty   = 8'h00;
        wait_ps1("t3a_wait_ps");
        hi = 0; ps_cnt = 0;
        for (int i = 1; i <= 6656; i++) begin
            step();
            hi += int'(out1[15]);
            ps_cnt += int'(ps1);
        end
        check("t3_duty00_high_clks", 32'(hi), 32'd0);
        check("t3_duty00_ps_count", 32'(ps_cnt), 32'd2);
        duty = 8'hFF;
        wait_ps1("t3b_wait_ps");
        hi = 0;
        for (int i = 1; i <= 6656; i++) begin
            step();
            hi += int'(out1[15]);
        end
        check("t3_dutyFF_high_clks", 32'(hi), 32'd6656);

        // ---- 4: mid-period duty change 0x40 -> 0xC0 at pwm_cnt 0x20 ----
        duty = 8'h40;
        wait_ps1("t4_wait_ps");
        hi = 0; hi_b = 0; ps_last = 1'b0;
        for (int i = 1; i <= 6656; i++) begin
            step();
            if (i <= 3328) hi += int'(out1[15]);
            else hi_b += int'(out1[15]);
            if (i == 3328) ps_last = ps1;
            if (i == 416) duty = 8'hC0;
        end
        check("t4_cur_period_high", 32'(hi), 32'd832);
        check("t4_ps_at_boundary", 32'(ps_last), 32'h1);
        check("t4_next_period_high", 32'(hi_b), 32'd2496);

        // ---- 5: mixed mux ----
        en_out = 16'h00F0;
        en_pwm = 16'h0030;
        duty   = 8'h80;
        wait_ps1("t5_wait_ps");
        hi = 0; bad = 0;
        for (int i = 1; i <= 3328; i++) begin
            step();
            hi += int'(out1[4]);
            bad += int'(out1[5] != out1[4]);
            bad += int'(out1[7:6] != 2'b11);
            bad += int'((out1 & 16'hFF0F) != 16'h0);
        end
        check("t5_pwm_pin_high", 32'(hi), 32'd1664);
        check("t5_mux_violations", 32'(bad), 32'd0);
        en_out = 16'h0000;
        step();
        check("t5_clear_en_1clk", 32'(out1), 32'h0);

        // ---- 6: CLK_DIV=1, duty 0x01 ----
        n = 0;
        while (!ps2 && n < 300) begin
            step();
            n++;
        end
        check("t6_found_ps", 32'(ps2), 32'h1);
        hi = 0; bad = 0; v_at1 = 1'b0; ps_last = 1'b0;
        for (int i = 1; i <= 256; i++) begin
            step();
            hi += int'(out2[0]);
            bad += int'(out2[15:1] != 15'h0);
            if (i == 1) v_at1 = out2[0];
            if (i == 256) ps_last = ps2;
        end
        check("t6_high_clks", 32'(hi), 32'd1);
        check("t6_high_at_idx1", 32'(v_at1), 32'h1);
        check("t6_ps_period_256", 32'(ps_last), 32'h1);
        check("t6_other_pins", 32'(bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
